dogx_serial_tx: RTL and testbench

Output-side serial transmitter for the DOGX converter. It accepts one converter sample per 3 MHz sampling strobe: the signed converter_output word plus the active alpha range flag. It frames each sample as a 16-bit word with a sequence count and parity, and shifts the word off-chip on two data lanes with a frame-sync marker, all in the CLK_24M domain. It sits directly after DOGX_digital_TOP and is the off-chip end of the sample stream.

---
 rtl/dogx_tx_pkg.sv | 27 ++
 rtl/dogx_tx_shifter.sv | 36 +++
 rtl/dogx_serial_tx.sv | 158 +++++++++++++++
 tb/tb_dogx_serial_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dogx_tx_pkg.sv
// Shared widths, FSM state and frame word layout for the DOGX serial transmitter.
package dogx_tx_pkg;

  localparam int DATA_W    = 11;
  localparam int SEQ_W     = 3;
  localparam int WORD_W    = DATA_W + SEQ_W + 2;
  localparam int FRAME_LEN = WORD_W / 2;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic              alpha;
    logic [DATA_W-1:0] sample;
    logic [SEQ_W-1:0]  seq;
    logic              parity;
  } frame_word_t;

  // Even parity over the whole word: the parity bit makes the XOR of all bits zero.
  function automatic logic frame_parity(input logic [WORD_W-2:0] body);
    return ^body;
  endfunction

endpackage

// File: rtl/dogx_tx_shifter.sv
// Two-lane parallel-load shift register; each lane shifts MSB first and refills with zeros.
module dogx_tx_shifter
  import dogx_tx_pkg::*;
(
  input  logic                 CLK_24M,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [FRAME_LEN-1:0] load_hi,
  input  logic [FRAME_LEN-1:0] load_lo,
  output logic [1:0]           lane_msb
);

  logic [FRAME_LEN-1:0] hi_r;
  logic [FRAME_LEN-1:0] lo_r;

  // Load has priority; zero fill empties the lanes by the end of every frame.
  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (load) begin
      hi_r <= load_hi;
      lo_r <= load_lo;
    end else if (shift) begin
      hi_r <= {hi_r[FRAME_LEN-2:0], 1'b0};
      lo_r <= {lo_r[FRAME_LEN-2:0], 1'b0};
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign lane_msb = {hi_r[FRAME_LEN-1], lo_r[FRAME_LEN-1]};

endmodule

// File: rtl/dogx_serial_tx.sv
// DOGX output transmitter: single-entry hold register, sequence/parity framing and
// a two-lane serial shifter with frame sync, all in the CLK_24M domain.
module dogx_serial_tx
  import dogx_tx_pkg::*;
(
  input  logic                     CLK_24M,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] converter_output,
  input  logic                     alpha_in,
  input  logic                     overflow_clr,
  output logic [1:0]               sdata,
  output logic                     frame_sync,
  output logic                     busy,
  output logic                     overflow
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  tx_state_t         state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              frame_sync_r;
  logic              busy_r;
  logic              overflow_r;
  logic              hold_full_r;
  logic              hold_alpha_r;
  logic [DATA_W-1:0] hold_sample_r;
  logic [SEQ_W-1:0]  seq_r;

  logic        frame_end_s;
  logic        load_s;
  logic        shift_s;
  logic        hold_wr_s;
  logic        drop_s;
  frame_word_t word_s;

  assign frame_end_s = (state_r == SHIFT) && (bit_cnt_r == LAST_BIT);
  assign load_s      = hold_full_r && ((state_r == IDLE) || frame_end_s);
  assign shift_s     = (state_r == SHIFT) && !load_s;
  // A loading hold entry frees its slot in the same edge, so a strobe then is accepted.
  assign hold_wr_s   = sample_valid && (!hold_full_r || load_s);
  assign drop_s      = sample_valid && hold_full_r && !load_s;

  assign word_s.alpha  = hold_alpha_r;
  assign word_s.sample = hold_sample_r;
  assign word_s.seq    = seq_r;
  assign word_s.parity = frame_parity({hold_alpha_r, hold_sample_r, seq_r});

  // Frame FSM with registered frame_sync and busy.
  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
      frame_sync_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bit_cnt_r <= '0;
          if (hold_full_r) begin
            state_r      <= SHIFT;
            frame_sync_r <= 1'b1;
            busy_r       <= 1'b1;
          end else begin
            state_r      <= IDLE;
            frame_sync_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_r <= '0;
            if (hold_full_r) begin
              state_r      <= SHIFT;
              frame_sync_r <= 1'b1;
              busy_r       <= 1'b1;
            end else begin
              state_r      <= IDLE;
              frame_sync_r <= 1'b0;
              busy_r       <= 1'b0;
            end
          end else begin
            state_r      <= SHIFT;
            bit_cnt_r    <= bit_cnt_r + CNT_W'(1);
            frame_sync_r <= 1'b0;
            busy_r       <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          bit_cnt_r    <= '0;
          frame_sync_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry hold register in front of the shifter.
  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      hold_full_r   <= 1'b0;
      hold_alpha_r  <= 1'b0;
      hold_sample_r <= '0;
    end else if (hold_wr_s) begin
      hold_full_r   <= 1'b1;
      hold_alpha_r  <= alpha_in;
      hold_sample_r <= converter_output;
    end else if (load_s) begin
      hold_full_r   <= 1'b0;
      hold_alpha_r  <= hold_alpha_r;
      hold_sample_r <= hold_sample_r;
    end else begin
      hold_full_r   <= hold_full_r;
      hold_alpha_r  <= hold_alpha_r;
      hold_sample_r <= hold_sample_r;
    end
  end

  // Sequence count advances after each load, so a frame carries the pre-increment value.
  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      seq_r <= '0;
    end else if (load_s) begin
      seq_r <= seq_r + SEQ_W'(1);
    end else begin
      seq_r <= seq_r;
    end
  end

  // Sticky drop flag; a drop at the clearing edge keeps it set.
  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  dogx_tx_shifter u_shifter (
    .CLK_24M  (CLK_24M),
    .reset    (reset),
    .load     (load_s),
    .shift    (shift_s),
    .load_hi  (word_s[WORD_W-1:FRAME_LEN]),
    .load_lo  (word_s[FRAME_LEN-1:0]),
    .lane_msb (sdata)
  );

  assign frame_sync = frame_sync_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_dogx_serial_tx.sv
// Directed self-checking bench for dogx_serial_tx; inputs driven and outputs sampled on negedge.
module tb_dogx_serial_tx;
  import dogx_tx_pkg::*;

  logic                     CLK_24M = 1'b0;
  logic                     reset = 1'b0;
  logic                     sample_valid = 1'b0;
  logic signed [DATA_W-1:0] converter_output = '0;
  logic                     alpha_in = 1'b0;
  logic                     overflow_clr = 1'b0;
  logic [1:0]               sdata;
  logic                     frame_sync;
  logic                     busy;
  logic                     overflow;

  int n_cmp = 0;
  int n_err = 0;

  dogx_serial_tx dut (
    .CLK_24M          (CLK_24M),
    .reset            (reset),
    .sample_valid     (sample_valid),
    .converter_output (converter_output),
    .alpha_in         (alpha_in),
    .overflow_clr     (overflow_clr),
    .sdata            (sdata),
    .frame_sync       (frame_sync),
    .busy             (busy),
    .overflow         (overflow)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] frame_of(input logic a, input logic [DATA_W-1:0] s,
                                                 input logic [SEQ_W-1:0] q);
    logic [WORD_W-2:0] b;
    b = {a, s, q};
    return {b, ^b};
  endfunction

  task automatic tick();
    @(negedge CLK_24M);
  endtask

  task automatic strobe_on(input logic [DATA_W-1:0] s, input logic a);
    sample_valid     = 1'b1;
    converter_output = s;
    alpha_in         = a;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    overflow_clr = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_sync(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (frame_sync) seen = 1'b1;
    end
  endtask

  // Collect one frame starting at the current (frame_sync) cycle.
  task automatic grab(output logic [WORD_W-1:0] w);
    w = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i > 0) tick();
      w[WORD_W-1-i]    = sdata[1];
      w[FRAME_LEN-1-i] = sdata[0];
    end
  endtask

  logic signed [DATA_W-1:0] ramp [10] = '{-11'sd1024, -11'sd512, -11'sd1, 11'sd0, 11'sd1,
                                           11'sd255, 11'sd511, 11'sd1023, 11'sd100, -11'sd300};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WORD_W-1:0] w;
    logic seen;
    int hits;

    // Reset state and a single sample
    tick(); tick(); tick();
    check_eq("rst_sdata", 32'(sdata), 32'd0);
    check_eq("rst_fsync", 32'(frame_sync), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();
    strobe_on(11'd5, 1'b1);
    tick();
    sample_valid = 1'b0;
    check_eq("t1_fsync_early", 32'(frame_sync), 32'd0);
    tick();
    check_eq("t1_fsync", 32'(frame_sync), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    grab(w);
    check_eq("t1_word", 32'(w), 32'h8051);
    tick();
    check_eq("t1_busy_fall", 32'(busy), 32'd0);
    check_eq("t1_sdata_idle", 32'(sdata), 32'd0);

    // Continuous strobes every 8 cycles
    do_reset();
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          strobe_on(ramp[k], k[0]);
          tick();
          sample_valid = 1'b0;
          repeat (7) tick();
        end
      end
      begin
        logic [WORD_W-1:0] w2;
        logic seen2;
        wait_sync(20, seen2);
        check_eq("t2_sync_seen", 32'(seen2), 32'd1);
        for (int k = 0; k < 10; k++) begin
          if (k > 0) begin
            tick();
            check_eq("t2_no_gap", 32'(frame_sync), 32'd1);
          end
          grab(w2);
          check_eq("t2_word", 32'(w2), 32'(frame_of(k[0], ramp[k], 3'(k))));
          check_eq("t2_even_parity", 32'(^w2), 32'd0);
          if (k == 0) begin
            check_eq("t3_neg1024_hi", 32'(w2[15:5]), 32'b010_0000_0000);
            check_eq("t3_neg1024_word", 32'(w2), 32'h4001);
          end
        end
      end
    join
    tick();
    check_eq("t2_ovf", 32'(overflow), 32'd0);
    check_eq("t2_busy_end", 32'(busy), 32'd0);

    // Strobes at 1-cycle spacing: third one dropped
    do_reset();
    fork
      begin
        strobe_on(11'd3, 1'b0);
        tick();
        strobe_on(11'h7FE, 1'b1);
        tick();
        strobe_on(11'd77, 1'b1);
        tick();
        sample_valid = 1'b0;
        check_eq("t4_ovf_set", 32'(overflow), 32'd1);
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
      end
      begin
        logic [WORD_W-1:0] w3;
        logic seen3;
        wait_sync(10, seen3);
        check_eq("t4_sync_seen", 32'(seen3), 32'd1);
        grab(w3);
        check_eq("t4_word_a", 32'(w3), 32'(frame_of(1'b0, 11'd3, 3'd0)));
        tick();
        check_eq("t4_fsync_b", 32'(frame_sync), 32'd1);
        grab(w3);
        check_eq("t4_word_b", 32'(w3), 32'(frame_of(1'b1, 11'h7FE, 3'd1)));
        tick();
        check_eq("t4_no_third", 32'(frame_sync), 32'd0);
        check_eq("t4_busy_end", 32'(busy), 32'd0);
      end
    join
    strobe_on(11'd10, 1'b0);
    tick();
    strobe_on(11'd11, 1'b0);
    tick();
    strobe_on(11'd12, 1'b0);
    overflow_clr = 1'b1;
    tick();
    sample_valid = 1'b0;
    overflow_clr = 1'b0;
    check_eq("t4_set_wins", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check_eq("t4_ovf_clr2", 32'(overflow), 32'd0);
    repeat (20) tick();

    // Reset mid-frame with the hold register full
    do_reset();
    strobe_on(11'd20, 1'b1);
    tick();
    strobe_on(11'd21, 1'b1);
    tick();
    strobe_on(11'd22, 1'b1);
    check_eq("t5_started", 32'(frame_sync), 32'd1);
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("t5_sdata", 32'(sdata), 32'd0);
    check_eq("t5_fsync", 32'(frame_sync), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_ovf_rst", 32'(overflow), 32'd0);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_sync || busy) hits++;
    end
    check_eq("t5_no_frame", 32'(hits), 32'd0);
    strobe_on(11'd9, 1'b0);
    tick();
    sample_valid = 1'b0;
    wait_sync(10, seen);
    check_eq("t5_sync_seen", 32'(seen), 32'd1);
    grab(w);
    check_eq("t5_word_seq0", 32'(w), 32'(frame_of(1'b0, 11'd9, 3'd0)));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
